// File: rtl/asteroid_mover.sv
// asteroid_mover: motion and lifecycle controller for one asteroid slot.
// It requests spawn parameters, latches them, and steps the position once per
// video frame. The asteroid is retired when it leaves the screen or is hit,
// and a new spawn is requested after a hold-off.
// Optional feature: define ASTEROID_WRAP_EN so that an asteroid leaving the
// screen wraps to the opposite edge instead of despawning.
module asteroid_mover #(
    parameter int SCR_W          = 640,
    parameter int SCR_H          = 480,
    parameter int RESPAWN_FRAMES = 60,
    parameter int EXPLODE_FRAMES = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iFrameTick,
    input  logic [2:0]  iDir,
    input  logic [10:0] iPosX,
    input  logic [10:0] iPosY,
    input  logic [1:0]  iSize,
    input  logic        iSpawn,
    input  logic        iHit,
    output logic [10:0] oPosX,
    output logic [10:0] oPosY,
    output logic [1:0]  oSize,
    output logic        oAlive,
    output logic        oExploding,
    output logic        oReqSpawn,
    output logic        oHitPulse
);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        REQ     = 2'd1,
        ACTIVE  = 2'd2,
        EXPLODE = 2'd3
    } state_t;

    localparam logic [10:0] MAX_X       = 11'(SCR_W);
    localparam logic [10:0] MAX_Y       = 11'(SCR_H);
    localparam logic [7:0]  RESPAWN_CNT = 8'(RESPAWN_FRAMES);
    localparam logic [7:0]  EXPLODE_CNT = 8'(EXPLODE_FRAMES);
`ifdef ASTEROID_WRAP_EN
    localparam logic [10:0] SPAN_X      = 11'(SCR_W + 1);
    localparam logic [10:0] SPAN_Y      = 11'(SCR_H + 1);
`endif

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [2:0]  dir_reg;
    logic [10:0] pos_x_reg;
    logic [10:0] pos_y_reg;
    logic [1:0]  size_reg;
    logic        hit_pulse_reg;

    logic [10:0] speed;
    logic        x_pos_dir;
    logic        x_neg_dir;
    logic        y_pos_dir;
    logic        y_neg_dir;
    logic [10:0] step_x;
    logic [10:0] step_y;
    logic        off_x;
    logic        off_y;
`ifdef ASTEROID_WRAP_EN
    logic [10:0] wrap_x;
    logic [10:0] wrap_y;
`endif

    // Candidate position one frame ahead, computed from the latched direction.
    // Underflow wraps modulo 2048 and so lands above the legal range.
    always_comb begin
        speed     = 11'(size_reg) + 11'd1;
        x_pos_dir = 1'b0;
        x_neg_dir = 1'b0;
        y_pos_dir = 1'b0;
        y_neg_dir = 1'b0;
        case (dir_reg)
            3'd0: y_neg_dir = 1'b1;
            3'd1: begin x_pos_dir = 1'b1; y_neg_dir = 1'b1; end
            3'd2: x_pos_dir = 1'b1;
            3'd3: begin x_pos_dir = 1'b1; y_pos_dir = 1'b1; end
            3'd4: y_pos_dir = 1'b1;
            3'd5: begin x_neg_dir = 1'b1; y_pos_dir = 1'b1; end
            3'd6: x_neg_dir = 1'b1;
            default: begin x_neg_dir = 1'b1; y_neg_dir = 1'b1; end
        endcase
        step_x = pos_x_reg;
        if (x_pos_dir)
            step_x = pos_x_reg + speed;
        else if (x_neg_dir)
            step_x = pos_x_reg - speed;
        step_y = pos_y_reg;
        if (y_pos_dir)
            step_y = pos_y_reg + speed;
        else if (y_neg_dir)
            step_y = pos_y_reg - speed;
        off_x = (step_x > MAX_X);
        off_y = (step_y > MAX_Y);
`ifdef ASTEROID_WRAP_EN
        // Re-enter from the opposite edge; 11-bit arithmetic gives the modulo.
        wrap_x = x_neg_dir ? (step_x + SPAN_X) : (step_x - SPAN_X);
        wrap_y = y_neg_dir ? (step_y + SPAN_Y) : (step_y - SPAN_Y);
`endif
    end

    // Lifecycle state machine with registered position, size and hit pulse.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_reg     <= WAIT;
            cnt_reg       <= 8'd0;
            dir_reg       <= 3'd0;
            pos_x_reg     <= 11'd0;
            pos_y_reg     <= 11'd0;
            size_reg      <= 2'd0;
            hit_pulse_reg <= 1'b0;
        end else begin
            hit_pulse_reg <= 1'b0;
            case (state_reg)
                WAIT: begin
                    if (iFrameTick) begin
                        if (cnt_reg + 8'd1 == RESPAWN_CNT) begin
                            cnt_reg   <= 8'd0;
                            state_reg <= REQ;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                REQ: begin
                    if (iSpawn) begin
                        dir_reg   <= iDir;
                        pos_x_reg <= iPosX;
                        pos_y_reg <= iPosY;
                        size_reg  <= iSize;
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A hit takes priority over a move in the same cycle.
                    if (iHit) begin
                        hit_pulse_reg <= 1'b1;
                        cnt_reg       <= 8'd0;
                        state_reg     <= EXPLODE;
                    end else if (iFrameTick) begin
`ifdef ASTEROID_WRAP_EN
                        pos_x_reg <= off_x ? wrap_x : step_x;
                        pos_y_reg <= off_y ? wrap_y : step_y;
`else
                        // Leaving the screen keeps the last on-screen position.
                        if (off_x || off_y) begin
                            cnt_reg   <= 8'd0;
                            state_reg <= WAIT;
                        end else begin
                            pos_x_reg <= step_x;
                            pos_y_reg <= step_y;
                        end
`endif
                    end
                end
                default: begin
                    if (iFrameTick) begin
                        if (cnt_reg + 8'd1 == EXPLODE_CNT) begin
                            cnt_reg   <= 8'd0;
                            state_reg <= WAIT;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign oPosX      = pos_x_reg;
    assign oPosY      = pos_y_reg;
    assign oSize      = size_reg;
    assign oAlive     = (state_reg == ACTIVE);
    assign oExploding = (state_reg == EXPLODE);
    assign oReqSpawn  = (state_reg == REQ);
    assign oHitPulse  = hit_pulse_reg;

endmodule

// File: doc/asteroid_mover.md
# asteroid_mover

Single-asteroid motion and lifecycle controller, and the consumer of the randomized spawn parameters (direction, X/Y position, size) produced by the asteroid spawn generator. It requests a spawn, latches the offered parameters, and steps the asteroid's position once per video frame. It retires the asteroid on screen exit or on a hit, then requests a new spawn after a hold-off. One instance per asteroid slot; its outputs feed the renderer and collision logic.

## Interface
- SCR_W, 640, maximum legal X (inclusive range 0..SCR_W)
- SCR_H, 480, maximum legal Y (inclusive range 0..SCR_H)
- RESPAWN_FRAMES, 60, frame ticks spent in WAIT before a spawn is requested (1..255)
- EXPLODE_FRAMES, 16, frame ticks spent in EXPLODE (1..255)
- iClk  in  1  system clock; all state changes on rising edge
- iRst  in  1  reset, asynchronous, active-low
- iFrameTick  in  1  one-cycle pulse per video frame
- iDir  in  3  spawn direction: 0=up(Y-), 1=up-right, 2=right, 3=down-right, 4=down, 5=down-left, 6=left, 7=up-left
- iPosX  in  11  spawn X
- iPosY  in  11  spawn Y
- iSize  in  2  spawn size code
- iSpawn  in  1  spawn grant; valid only while oReqSpawn=1
- iHit  in  1  collision report for this asteroid
- oPosX  out  11  current X
- oPosY  out  11  current Y
- oSize  out  2  current size code
- oAlive  out  1  asteroid is on screen and collidable
- oExploding  out  1  explosion animation active
- oReqSpawn  out  1  requesting new spawn parameters
- oHitPulse  out  1  one-cycle pulse on accepted hit (score event)

## Operation
- States: WAIT, REQ, ACTIVE, EXPLODE. Frame counter: 8 bits.
- WAIT: counter increments on each iFrameTick. When the count reaches RESPAWN_FRAMES, clear the counter and go to REQ.
- REQ: oReqSpawn=1. If iSpawn=1, latch iDir, iPosX, iPosY and iSize into internal registers and go to ACTIVE. iSpawn in any other state is ignored.
- ACTIVE: oAlive=1. Speed s = oSize+1 px/frame. On iFrameTick, X moves by dx∈{-s,0,+s} and Y by dy∈{-s,0,+s} according to the latched direction. Diagonals move both axes by s.
- Arithmetic is 11-bit unsigned. A position is off-screen if the new X > SCR_W or the new Y > SCR_H; underflow below 0 wraps to ≥2047-s and is therefore off-screen.
- Off-screen in ACTIVE: go to WAIT with counter cleared. oPosX and oPosY hold the last on-screen value. No oHitPulse.
- iHit in ACTIVE: go to EXPLODE, pulse oHitPulse for one cycle, clear the counter, freeze the position. iHit in WAIT, REQ or EXPLODE is ignored.
- EXPLODE: oExploding=1, oAlive=0. Counter increments on iFrameTick. At EXPLODE_FRAMES, clear the counter and go to WAIT.

## Timing
- Reset values: oPosX=0, oPosY=0, oSize=0, oAlive=0, oExploding=0, oReqSpawn=0, oHitPulse=0; state WAIT; counter 0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.
- Spawn latency: the iSpawn edge loads the registers; oAlive=1 and the spawn values appear on oPosX, oPosY and oSize on the same edge.
- Move latency: the position updates on the edge that samples iFrameTick=1.
- iHit and iFrameTick in the same cycle: the hit wins and no move occurs.
- Inputs are sampled on the rising edge. The spawn generator updates on the falling edge, so its values are stable at sampling.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). On release the block resumes in WAIT.

## Configuration
- ASTEROID_WRAP_EN defined: an off-screen axis wraps instead of despawning. X > SCR_W (including underflow) becomes X+(SCR_W+1) modulo 2048 if the move was negative, or X−(SCR_W+1) if positive. Y behaves the same with SCR_H. The block stays in ACTIVE; it leaves only on a hit.
- ASTEROID_WRAP_EN undefined: off-screen despawns as described under Operation.

## Test plan
- Reset then RESPAWN_FRAMES=2: after 2 iFrameTick pulses, oReqSpawn=1. Before that, iSpawn=1 has no effect.
- Spawn (640,435) dir=5 size=1, then one tick -> oPosX=638, oPosY=437, oAlive=1.
- Spawn (0,125) dir=7 size=3, then one tick. Without the macro -> oAlive=0, state WAIT, oPosX=0, oPosY=125. With ASTEROID_WRAP_EN -> oPosX=637, oPosY=121, oAlive=1.
- Active asteroid, iHit and iFrameTick in the same cycle -> no move, oHitPulse high for 1 cycle, oExploding=1. With EXPLODE_FRAMES=4, after 4 ticks -> oExploding=0 and state WAIT.
- iHit during WAIT, REQ or EXPLODE -> no oHitPulse and no state change.
- Reset asserted while ACTIVE mid-frame -> all outputs are immediately 0. After release, a full RESPAWN_FRAMES elapses before oReqSpawn is raised.
